// File: rtl/tpu_job_dispatcher.sv
// rtl/tpu_job_dispatcher.sv - job queue and start/valid sequencer for the matrix-multiply accelerator (option: TPU_DISPATCH_PERF_EN)
module tpu_job_dispatcher #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [ADDR_WIDTH-1:0]      job_m_i,
    input  logic [ADDR_WIDTH-1:0]      job_k_i,
    input  logic [ADDR_WIDTH-1:0]      job_n_i,
    input  logic [ADDR_WIDTH-1:0]      job_base_a_i,
    input  logic [ADDR_WIDTH-1:0]      job_base_b_i,
    input  logic [ADDR_WIDTH-1:0]      job_base_p_i,
    input  logic                       flush_i,
    output logic                       start_o,
    input  logic                       valid_i,
    output logic [ADDR_WIDTH-1:0]      m_o,
    output logic [ADDR_WIDTH-1:0]      k_o,
    output logic [ADDR_WIDTH-1:0]      n_o,
    output logic [ADDR_WIDTH-1:0]      base_addra_o,
    output logic [ADDR_WIDTH-1:0]      base_addrb_o,
    output logic [ADDR_WIDTH-1:0]      base_addrp_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     pending_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [31:0]                done_cycles_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] m;
        logic [ADDR_WIDTH-1:0] k;
        logic [ADDR_WIDTH-1:0] n;
        logic [ADDR_WIDTH-1:0] a;
        logic [ADDR_WIDTH-1:0] b;
        logic [ADDR_WIDTH-1:0] p;
    } job_t;

    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

    state_t            state_q, state_d;
    job_t              mem [DEPTH];
    job_t              head;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push, pop, issue, drop, complete, head_legal;

    assign job_ready_o = (count_q != CNT_W'(DEPTH));
    assign pending_o   = count_q;
    assign push        = job_valid_i && job_ready_o && !flush_i;
    assign head        = mem[rd_ptr_q];
    assign head_legal  = (head.m != '0) && (head.k != '0) && (head.n != '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= '{m: job_m_i, k: job_k_i, n: job_n_i,
                               a: job_base_a_i, b: job_base_b_i, p: job_base_p_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // A flush wins over both issuing and dropping the head in IDLE.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        issue    = 1'b0;
        drop     = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0 && !flush_i) begin
                    if (!head_legal) begin
                        pop  = 1'b1;
                        drop = 1'b1;
                    end else if (!valid_i) begin
                        pop     = 1'b1;
                        issue   = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (valid_i) begin
                    complete = 1'b1;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                if (!valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            start_o      <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
            m_o          <= '0;
            k_o          <= '0;
            n_o          <= '0;
            base_addra_o <= '0;
            base_addrb_o <= '0;
            base_addrp_o <= '0;
        end else begin
            state_q <= state_d;
            done_o  <= complete;
            err_o   <= drop;
            busy_o  <= (state_d != IDLE);
            if (issue) begin
                start_o      <= 1'b1;
                m_o          <= head.m;
                k_o          <= head.k;
                n_o          <= head.n;
                base_addra_o <= head.a;
                base_addrb_o <= head.b;
                base_addrp_o <= head.p;
            end else if (complete) begin
                start_o <= 1'b0;
            end
        end
    end

`ifdef TPU_DISPATCH_PERF_EN
    logic [31:0] run_cnt_q, done_cycles_q, run_next;

    // Counts edges spent in RUN, including the issue edge and the completing edge.
    assign run_next = (&run_cnt_q) ? run_cnt_q : run_cnt_q + 32'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_cnt_q     <= '0;
            done_cycles_q <= '0;
        end else begin
            if (issue)                 run_cnt_q <= 32'd1;
            else if (state_q == RUN)   run_cnt_q <= run_next;
            if (complete)              done_cycles_q <= run_next;
        end
    end

    assign done_cycles_o = done_cycles_q;
`else
    assign done_cycles_o = '0;
`endif

endmodule

// File: tb/tb_tpu_job_dispatcher.sv
// tb/tb_tpu_job_dispatcher.sv - randomized self-checking bench for tpu_job_dispatcher
module tb_tpu_job_dispatcher;
    typedef struct packed {
        logic [15:0] m;
        logic [15:0] k;
        logic [15:0] n;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
    } job_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0;
    logic        flush = 1'b0;
    logic        valid_i = 1'b0;
    logic [15:0] job_m = '0, job_k = '0, job_n = '0, job_a = '0, job_b = '0, job_p = '0;
    logic        job_ready, start_o, busy_o, done_o, err_o;
    logic [15:0] m_o, k_o, n_o, a_o, b_o, p_o;
    logic [2:0]  pending_o;
    logic [31:0] done_cycles_o;
    job_t        dut_desc;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // controller model knobs
    int lat = 4;
    bit stall = 1'b0;

    // monitor state
    int   rise_cnt = 0, done_cnt = 0, err_cnt = 0, desc_chg = 0, fall_cyc = -1;
    bit   prev_start = 1'b0;
    job_t prev_desc;
    job_t issued[$];
    int   gaps[$];

`ifdef TPU_DISPATCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    tpu_job_dispatcher #(.ADDR_WIDTH(16), .DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .job_valid_i(job_valid), .job_ready_o(job_ready),
        .job_m_i(job_m), .job_k_i(job_k), .job_n_i(job_n),
        .job_base_a_i(job_a), .job_base_b_i(job_b), .job_base_p_i(job_p),
        .flush_i(flush), .start_o(start_o), .valid_i(valid_i),
        .m_o(m_o), .k_o(k_o), .n_o(n_o),
        .base_addra_o(a_o), .base_addrb_o(b_o), .base_addrp_o(p_o),
        .busy_o(busy_o), .pending_o(pending_o), .done_o(done_o), .err_o(err_o),
        .done_cycles_o(done_cycles_o)
    );

    assign dut_desc = {m_o, k_o, n_o, a_o, b_o, p_o};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Accelerator controller: raises valid lat edges after seeing start, drops it one cycle after start falls.
    initial begin : ctrl
        int  cnt;
        bit  seen_low;
        cnt = 0;
        seen_low = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                valid_i = 1'b0; cnt = 0; seen_low = 1'b0;
            end else if (!valid_i) begin
                if (start_o && !stall) begin
                    cnt++;
                    if (cnt >= lat) valid_i = 1'b1;
                end
            end else if (!start_o) begin
                if (seen_low) begin
                    valid_i = 1'b0; cnt = 0; seen_low = 1'b0;
                end else begin
                    seen_low = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
        end else begin
            if (start_o && !prev_start) begin
                rise_cnt++;
                issued.push_back(dut_desc);
                if (fall_cyc >= 0) gaps.push_back(cyc - fall_cyc);
            end
            if (!start_o && prev_start) fall_cyc = cyc;
            if (start_o && prev_start && dut_desc !== prev_desc) desc_chg++;
            done_cnt += int'(done_o);
            err_cnt  += int'(err_o);
            prev_start = start_o;
            prev_desc  = dut_desc;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic job_t rand_job(input bit legal);
        job_t j;
        j.m = 16'($urandom_range(1, 64));
        j.k = 16'($urandom_range(1, 64));
        j.n = 16'($urandom_range(1, 64));
        j.a = 16'($urandom_range(0, 16'hFFFF));
        j.b = 16'($urandom_range(0, 16'hFFFF));
        j.p = 16'($urandom_range(0, 16'hFFFF));
        if (!legal) begin
            case ($urandom_range(0, 2))
                0: j.m = '0;
                1: j.k = '0;
                default: j.n = '0;
            endcase
        end
        return j;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        job_valid = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input job_t j, input int max_wait, output bit acc);
        bit ready_now;
        {job_m, job_k, job_n, job_a, job_b, job_p} = j;
        job_valid = 1'b1;
        acc = 1'b0;
        for (int w = 0; w < max_wait && !acc; w++) begin
            @(negedge clk);
            ready_now = job_ready;
            @(posedge clk);
            #1;
            acc = ready_now;
        end
        job_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = !busy_o && !start_o && pending_o == 0 && !valid_i;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++; if (start_o !== 1'b0) begin tests_failed++; $display("FAIL reset_start got %0b want 0", start_o); end
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        tests_run++; if ({done_o, err_o} !== 2'b00) begin tests_failed++; $display("FAIL reset_pulses got %b want 00", {done_o, err_o}); end
        tests_run++; if (job_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %0b want 1", job_ready); end
        tests_run++; if (pending_o !== 3'd0) begin tests_failed++; $display("FAIL reset_pending got %0d want 0", pending_o); end
        tests_run++; if (dut_desc !== '0) begin tests_failed++; $display("FAIL reset_desc got %h want 0", dut_desc); end
        tests_run++; if (done_cycles_o !== 32'd0) begin tests_failed++; $display("FAIL reset_done_cycles got %0d want 0", done_cycles_o); end
    endtask

    task automatic test_single();
        job_t j;
        bit   acc, seen, ok;
        int   d0;
        do_reset();
        lat = 20;
        j = '{m: 16'd8, k: 16'd8, n: 16'd8, a: 16'h000, b: 16'h100, p: 16'h200};
        d0 = done_cnt;
        push_job(j, 4, acc);
        tests_run++; if (acc !== 1'b1 || pending_o !== 3'd1 || start_o !== 1'b0) begin tests_failed++;
            $display("FAIL single_e0 got acc=%0b pending=%0d start=%0b want 1/1/0", acc, pending_o, start_o); end
        @(posedge clk); #1;
        tests_run++; if (start_o !== 1'b1 || pending_o !== 3'd0 || busy_o !== 1'b1) begin tests_failed++;
            $display("FAIL single_e1 got start=%0b pending=%0d busy=%0b want 1/0/1", start_o, pending_o, busy_o); end
        tests_run++; if (dut_desc !== j) begin tests_failed++; $display("FAIL single_desc got %h want %h", dut_desc, j); end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            seen = done_o;
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL single_done_wait got no done want done"); end
        tests_run++; if (done_cycles_o !== (PERF ? 32'd21 : 32'd0)) begin tests_failed++;
            $display("FAIL single_done_cycles got %0d want %0d", done_cycles_o, PERF ? 21 : 0); end
        wait_quiet(20, ok);
        tests_run++; if (!ok || done_cnt - d0 !== 1) begin tests_failed++;
            $display("FAIL single_done_count got quiet=%0b done=%0d want 1/1", ok, done_cnt - d0); end
        tests_run++; if (dut_desc !== j) begin tests_failed++; $display("FAIL single_desc_hold got %h want %h", dut_desc, j); end
    endtask

    task automatic test_queue_full();
        job_t js[6];
        bit   acc;
        int   n_acc;
        do_reset();
        stall = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 6; i++) js[i] = rand_job(1'b1);
        for (int i = 0; i < 5; i++) begin
            push_job(js[i], 1, acc);
            n_acc += int'(acc);
        end
        tests_run++; if (n_acc !== 5) begin tests_failed++; $display("FAIL full_accepts got %0d want 5", n_acc); end
        tests_run++; if (pending_o !== 3'd4 || job_ready !== 1'b0) begin tests_failed++;
            $display("FAIL full_state got pending=%0d ready=%0b want 4/0", pending_o, job_ready); end
        tests_run++; if (start_o !== 1'b1 || dut_desc !== js[0]) begin tests_failed++;
            $display("FAIL full_issue got start=%0b desc=%h want 1/%h", start_o, dut_desc, js[0]); end
        push_job(js[5], 1, acc);
        tests_run++; if (acc !== 1'b0 || pending_o !== 3'd4) begin tests_failed++;
            $display("FAIL full_refuse got acc=%0b pending=%0d want 0/4", acc, pending_o); end
    endtask

    task automatic test_illegal();
        job_t bad, good;
        bit   acc, ok;
        int   d0, e0;
        do_reset();
        lat = 3;
        bad = rand_job(1'b1);
        bad.k = '0;
        good = rand_job(1'b1);
        d0 = done_cnt; e0 = err_cnt;
        push_job(bad, 2, acc);
        push_job(good, 2, acc);
        tests_run++; if (err_o !== 1'b1 || start_o !== 1'b0) begin tests_failed++;
            $display("FAIL illegal_err got err=%0b start=%0b want 1/0", err_o, start_o); end
        @(posedge clk); #1;
        tests_run++; if (err_o !== 1'b0 || start_o !== 1'b1 || dut_desc !== good) begin tests_failed++;
            $display("FAIL illegal_next got err=%0b start=%0b desc=%h want 0/1/%h", err_o, start_o, dut_desc, good); end
        wait_quiet(50, ok);
        tests_run++; if (!ok || err_cnt - e0 !== 1 || done_cnt - d0 !== 1) begin tests_failed++;
            $display("FAIL illegal_counts got quiet=%0b err=%0d done=%0d want 1/1/1", ok, err_cnt - e0, done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        job_t exp_q[$];
        job_t j;
        bit   acc, ok;
        int   d0, c0, bad_gaps;
        do_reset();
        lat = $urandom_range(1, 5);
        issued.delete(); gaps.delete(); fall_cyc = -1;
        d0 = done_cnt; c0 = desc_chg;
        for (int i = 0; i < 3; i++) begin
            j = rand_job(1'b1);
            exp_q.push_back(j);
            push_job(j, 50, acc);
        end
        wait_quiet(200, ok);
        tests_run++; if (!ok || done_cnt - d0 !== 3) begin tests_failed++;
            $display("FAIL b2b_done got quiet=%0b done=%0d want 1/3", ok, done_cnt - d0); end
        tests_run++; if (issued.size() !== 3) begin tests_failed++;
            $display("FAIL b2b_issued got %0d want 3", issued.size()); end
        for (int i = 0; i < 3 && i < issued.size(); i++) begin
            tests_run++; if (issued[i] !== exp_q[i]) begin tests_failed++;
                $display("FAIL b2b_desc%0d got %h want %h", i, issued[i], exp_q[i]); end
        end
        bad_gaps = 0;
        foreach (gaps[i]) if (gaps[i] != 3) bad_gaps++;
        tests_run++; if (gaps.size() !== 2 || bad_gaps !== 0) begin tests_failed++;
            $display("FAIL b2b_gap got n=%0d bad=%0d want 2/0", gaps.size(), bad_gaps); end
        tests_run++; if (desc_chg - c0 !== 0) begin tests_failed++;
            $display("FAIL b2b_desc_stable got %0d changes want 0", desc_chg - c0); end
        tests_run++; if (done_cycles_o !== (PERF ? 32'(lat + 1) : 32'd0)) begin tests_failed++;
            $display("FAIL b2b_done_cycles got %0d want %0d", done_cycles_o, PERF ? lat + 1 : 0); end
    endtask

    task automatic test_flush();
        job_t j;
        bit   acc, ok;
        int   d0, r0;
        do_reset();
        stall = 1'b1;
        lat = 2;
        d0 = done_cnt; r0 = rise_cnt;
        for (int i = 0; i < 4; i++) push_job(rand_job(1'b1), 1, acc);
        tests_run++; if (pending_o !== 3'd3 || start_o !== 1'b1) begin tests_failed++;
            $display("FAIL flush_setup got pending=%0d start=%0b want 3/1", pending_o, start_o); end
        j = rand_job(1'b1);
        {job_m, job_k, job_n, job_a, job_b, job_p} = j;
        job_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        flush = 1'b0;
        tests_run++; if (pending_o !== 3'd0 || start_o !== 1'b1 || job_ready !== 1'b1) begin tests_failed++;
            $display("FAIL flush_empty got pending=%0d start=%0b ready=%0b want 0/1/1", pending_o, start_o, job_ready); end
        stall = 1'b0;
        wait_quiet(50, ok);
        repeat (5) @(posedge clk);
        #1;
        tests_run++; if (!ok || done_cnt - d0 !== 1 || rise_cnt - r0 !== 1) begin tests_failed++;
            $display("FAIL flush_after got quiet=%0b done=%0d starts=%0d want 1/1/1", ok, done_cnt - d0, rise_cnt - r0); end
    endtask

    task automatic test_reset_mid();
        job_t j;
        bit   acc, ok;
        int   r0;
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) push_job(rand_job(1'b1), 1, acc);
        tests_run++; if (start_o !== 1'b1 || pending_o !== 3'd2) begin tests_failed++;
            $display("FAIL rstmid_setup got start=%0b pending=%0d want 1/2", start_o, pending_o); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (start_o !== 1'b0 || pending_o !== 3'd0 || busy_o !== 1'b0) begin tests_failed++;
            $display("FAIL rstmid_async got start=%0b pending=%0d busy=%0b want 0/0/0", start_o, pending_o, busy_o); end
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        lat = 2;
        r0 = rise_cnt;
        repeat (6) @(posedge clk);
        #1;
        tests_run++; if (rise_cnt - r0 !== 0 || start_o !== 1'b0) begin tests_failed++;
            $display("FAIL rstmid_no_issue got starts=%0d start=%0b want 0/0", rise_cnt - r0, start_o); end
        j = rand_job(1'b1);
        push_job(j, 2, acc);
        @(posedge clk); #1;
        tests_run++; if (start_o !== 1'b1 || dut_desc !== j) begin tests_failed++;
            $display("FAIL rstmid_new got start=%0b desc=%h want 1/%h", start_o, dut_desc, j); end
        wait_quiet(50, ok);
    endtask

    task automatic test_random();
        job_t exp_q[$];
        job_t j;
        bit   acc, ok, legal;
        int   d0, e0, exp_err, mism;
        do_reset();
        lat = $urandom_range(1, 6);
        issued.delete();
        d0 = done_cnt; e0 = err_cnt; exp_err = 0;
        for (int i = 0; i < 12; i++) begin
            legal = ($urandom_range(0, 3) != 0);
            j = rand_job(legal);
            if (legal) exp_q.push_back(j); else exp_err++;
            push_job(j, 200, acc);
            if (!acc) begin
                tests_run++; tests_failed++;
                $display("FAIL random_push%0d got not accepted want accepted", i);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_quiet(500, ok);
        tests_run++; if (!ok || issued.size() !== exp_q.size()) begin tests_failed++;
            $display("FAIL random_issued got quiet=%0b n=%0d want 1/%0d", ok, issued.size(), exp_q.size()); end
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < issued.size(); i++) if (issued[i] !== exp_q[i]) mism++;
        tests_run++; if (mism !== 0) begin tests_failed++; $display("FAIL random_order got %0d mismatched want 0", mism); end
        tests_run++; if (err_cnt - e0 !== exp_err || done_cnt - d0 !== exp_q.size()) begin tests_failed++;
            $display("FAIL random_counts got err=%0d done=%0d want %0d/%0d", err_cnt - e0, done_cnt - d0, exp_err, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue_full();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
